main_mem_responder: RTL
=======================

// Module: main_mem_responder
// PURPOSE
// - Backing-store responder on the miss/refill side of direct_cmem: serves the single-word read
//   (line refill) and write (write-through) requests the cache issues on a miss or a store.
// - Models a slow main memory: every request occupies a fixed LAT-cycle access window, then a
//   response handshake.
// - One request in flight at a time.
// PARAMETERS
// - ADDR_W  6  request address width; the array holds 2**ADDR_W words
// - DATA_W  8  data word width
// - LAT     4  access wait cycles between request accept and response (0 allowed)
// PORTS
// - clk         in   1       rising-edge clock
// - rst         in   1       synchronous, active-low reset
// - req_valid   in   1       request present
// - req_ready   out  1       responder can accept a request (1 only in IDLE)
// - req_we      in   1       1=write, 0=read; sampled at accept
// - req_addr    in   ADDR_W  word address; sampled at accept
// - req_wdata   in   DATA_W  write data; sampled at accept
// - resp_valid  out  1       response present; held until taken
// - resp_ready  in   1       requester takes response
// - resp_rdata  out  DATA_W  read: array word; write: the data written
// - resp_we     out  1       echo of req_we for the response being presented
// BEHAVIOUR
// - Clock/reset: one clock clk; reset is synchronous and active-low (rst).
// - Reset (rst=0 at an edge):
//   - FSM goes to IDLE; wait counter is 0.
//   - req_ready=1, resp_valid=0, resp_rdata=0, resp_we=0.
//   - Every array word is cleared to 0.
// - Accept:
//   - A request is accepted at edge k iff req_valid && req_ready.
//   - addr, we and wdata are latched at that edge.
//   - req_valid while not in IDLE is ignored (not queued); the requester must hold it.
// - FSM: IDLE -> WAIT -> RESP -> IDLE.
//   - IDLE: req_ready=1. On accept:
//     - LAT>0: go to WAIT, cnt=LAT-1.
//     - LAT=0: commit, then go straight to RESP.
//   - WAIT: req_ready=0.
//     - cnt!=0: cnt decrements each edge.
//     - cnt==0: commit, then go to RESP.
//   - Commit, at the edge leaving for RESP:
//     - Write: array[addr]<=wdata, resp_rdata<=wdata.
//     - Read: resp_rdata<=array[addr].
//     - resp_we<=latched we in both cases.
//   - RESP: resp_valid=1 with stable resp_rdata and resp_we until resp_valid && resp_ready at an edge.
//     - At that edge: resp_valid<=0, return to IDLE.
//     - A new request can be accepted on the following edge, never the same edge.
// - Latency:
//   - resp_valid is first high after edge k+LAT.
//   - Minimum request-to-request spacing is LAT+2 cycles.
// - Ordering:
//   - A read following a write to the same address returns the new data.
//   - A write never modifies the array before its commit edge.
// - Reset mid-operation (WAIT or RESP):
//   - The transaction is abandoned and the pending response is dropped.
//   - An uncommitted write is NOT performed.
//   - Then full reset values apply.
// - Address wrap: req_addr is always within the array; no out-of-range case exists.
// CONFIGURATION
// - MAIN_MEM_STATS_EN defined: adds outputs rd_count and wr_count (16 bits each, out).
//   - Each increments by 1 at the commit edge of a read or write respectively.
//   - Each wraps 0xFFFF -> 0x0000.
//   - Both reset to 0.
//   - An abandoned transaction is not counted.
// - MAIN_MEM_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
// - Reset: hold rst=0 for 2 edges -> req_ready=1, resp_valid=0, resp_rdata=0; a read of addr 5 returns 0x00.
// - Write/read, LAT=4:
//   - Write 0xA5 to addr 5, accepted at edge k -> resp_valid rises after edge k+4, resp_we=1, resp_rdata=0xA5.
//   - A following read of addr 5 returns 0xA5.
// - Sequence over addrs 5/15/25 = A5/5A/3C:
//   - Read back 5, 15, 25 -> A5, 5A, 3C.
//   - Overwrite 25 with C3, read 25 -> C3.
//   - Write C3 to addr 9, read 9 -> C3.
// - Backpressure: hold resp_ready=0 for 6 cycles in RESP -> resp_valid and resp_rdata stable; req_ready=0 throughout.
// - Reset mid-WAIT: write 0x77 to addr 3, assert rst two cycles after accept -> no response; a read of addr 3 returns 0x00.
// - LAT=0 build: read accepted at edge k -> resp_valid after edge k.
//   - With MAIN_MEM_STATS_EN: 3 writes and 4 reads give wr_count=3, rd_count=4.

Source files
------------

// File: rtl/main_mem_responder.sv
// -----------------------------------------------------------------------------
// main_mem_responder
//   Slow backing-store model on the miss/refill side of direct_cmem. Serves
//   single-word reads (line refill) and writes (write-through), one request
//   in flight at a time. Every request spends a fixed LAT-cycle access window
//   before its response is presented and held until taken.
//
// Parameters
//   ADDR_W  word address width; the array holds 2**ADDR_W words
//   DATA_W  data word width
//   LAT     access wait cycles between accept and response (0 allowed)
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-low reset
//   req_valid   in   request present
//   req_ready   out  request can be accepted (high only in IDLE)
//   req_we      in   1 = write, 0 = read; sampled at accept
//   req_addr    in   word address; sampled at accept
//   req_wdata   in   write data; sampled at accept
//   resp_valid  out  response present; held until taken
//   resp_ready  in   requester takes the response
//   resp_rdata  out  read: array word; write: the data written
//   resp_we     out  req_we of the response being presented
//
// Optional feature (macro MAIN_MEM_STATS_EN)
//   rd_count    out  16-bit count of committed reads (wraps)
//   wr_count    out  16-bit count of committed writes (wraps)
// -----------------------------------------------------------------------------
module main_mem_responder #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_we
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LAT > 0) ? CNT_W'(LAT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              commit;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;

    assign accept = req_valid && req_ready;

    // The commit edge is the one leaving for RESP. With LAT=0 that is the
    // accept edge itself, so the request fields are used straight from the
    // ports instead of the latched copies.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        commit  = 1'b0;
        c_we    = lat_we;
        c_addr  = lat_addr;
        c_wdata = lat_wdata;
        if (state == S_IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            commit  = accept && (LAT == 0);
        end else if (state == S_WAIT) begin
            commit  = (cnt == '0);
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_we    <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (LAT == 0) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    // req_ready only rises here, so a new request can be
                    // accepted on the edge after the handshake, never on it.
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (commit) begin
                resp_we    <= c_we;
                resp_rdata <= c_we ? c_wdata : mem[c_addr];
            end
        end
    end

    // Storage array. Writes land only at the commit edge, so a reset during
    // WAIT drops an uncommitted write.
    always_ff @(posedge clk) begin
        // NOTE: this array is register-based and cleared word by word on
        // reset; a RAM macro could not be reset this way.
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit && c_we) begin
            mem[c_addr] <= c_wdata;
        end
    end

`ifdef MAIN_MEM_STATS_EN
    // Counters advance only at commit, so abandoned transactions are not seen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (commit) begin
            if (c_we) begin
                wr_count <= wr_count + 16'd1;
            end else begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule
